// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared digit constants, FSM encoding and power-of-ten helper for the BCD converter
package bin2bcd_seq_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bin2bcd_seq_add3: double-dabble correction cell, adds 3 to a BCD digit of 5 or more
module bin2bcd_seq_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] q_o
);
  assign q_o = d_i >= ADD3_THRESH ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble binary-to-BCD converter with saturation and leading-zero blanking
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int SATURATE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow,
  output logic [DIGITS-1:0]             blank
);
  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  // wide enough for 10^8 as well as the full input width
  localparam int LW = BIN_W > 30 ? BIN_W : 30;
  localparam logic [LW-1:0] LIMIT = LW'(pow10(DIGITS));

  state_e state_q, state_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [SW-1:0] scr_q, scr_d, cor, fin, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, ovf_o_q, ovf_o_d, accept, shift, last, z;
  logic [DIGITS-1:0] blank_q, blank_d, blank_n;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bin2bcd_seq_add3 u_add3 (.d_i(scr_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]), .q_o(cor[BCD_DIGIT_W*i +: BCD_DIGIT_W]));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ovf_o_q <= 1'b0;
      bcd_q   <= '0;
      blank_q <= ~DIGITS'(1);
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ovf_o_q <= ovf_o_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end

  always_comb
    state_d = state_q == S_IDLE  ? (start ? S_SHIFT : S_IDLE) :
              state_q == S_SHIFT ? (cnt_q == CW'(1) ? S_DONE : S_SHIFT) : S_IDLE;

  always_comb begin
    busy = state_q == S_SHIFT;
    done = state_q == S_DONE;
    bcd = bcd_q;
    overflow = ovf_o_q;
    blank = blank_q;
  end

  // results are registered on the final shift edge so they are valid throughout the done cycle
  always_comb begin
    accept  = state_q == S_IDLE && start;
    shift   = state_q == S_SHIFT;
    last    = shift && cnt_q == CW'(1);
    shreg_d = accept ? bin : shift ? shreg_q << 1 : shreg_q;
    scr_d   = accept ? '0 : shift ? SW'({cor, shreg_q[BIN_W-1]}) : scr_q;
    cnt_d   = accept ? CW'(BIN_W) : shift ? cnt_q - CW'(1) : cnt_q;
    ovf_d   = accept ? LW'(bin) >= LIMIT : ovf_q;
    fin     = SATURATE != 0 && ovf_q ? {DIGITS{BCD_MAX_DIGIT}} : scr_d;
    bcd_d   = last ? fin : bcd_q;
    ovf_o_d = last ? ovf_q : ovf_o_q;
    blank_d = last ? blank_n : blank_q;
  end

  always_comb begin
    z = 1'b1;
    blank_n = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z && fin[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0;
      blank_n[i] = z;
    end
    blank_n[0] = 1'b0;
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of three converter configurations against an arithmetic model
module tb_bin2bcd_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [13:0] bin0 = '0, bin1 = '0;
  logic [7:0] bin2 = '0;
  logic busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [15:0] bcd0, bcd1;
  logic [11:0] bcd2;
  logic [3:0] blank0, blank1;
  logic [2:0] blank2;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .SATURATE(1)) u_sat (.clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0), .blank(blank0));
  bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .SATURATE(0)) u_mod (.clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1), .blank(blank1));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SATURATE(1)) u_small (.clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2), .blank(blank2));

  function automatic logic [15:0] bcd_of(input int s);
    return s == 0 ? bcd0 : s == 1 ? bcd1 : {4'h0, bcd2};
  endfunction
  function automatic logic [3:0] blank_of(input int s);
    return s == 0 ? blank0 : s == 1 ? blank1 : {1'b0, blank2};
  endfunction
  function automatic logic ovf_of(input int s);
    return s == 0 ? ovf0 : s == 1 ? ovf1 : ovf2;
  endfunction
  function automatic logic done_of(input int s);
    return s == 0 ? done0 : s == 1 ? done1 : done2;
  endfunction

  // decimal digits by repeated division; saturation means the largest DIGITS-digit number
  function automatic void model(input int unsigned v, input int nd, input bit sat,
                                output logic [15:0] b, output logic o, output logic [3:0] bl);
    int unsigned lim = 1, p;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    o = v >= lim;
    p = (o && sat) ? lim - 1 : v % lim;
    b = '0;
    bl = '0;
    for (int i = 0; i < nd; i++) begin
      bl[i] = i > 0 && p == 0;
      b[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
  endfunction

  task automatic drive(input int s, input logic st, input logic [13:0] v);
    start0 = s == 0 && st;
    start1 = s == 1 && st;
    start2 = s == 2 && st;
    bin0 = v;
    bin1 = v;
    bin2 = v[7:0];
  endtask

  task automatic convert(input int s, input logic [13:0] v, output logic [15:0] b, output logic o,
                         output logic [3:0] bl, output int nd, output int lat);
    int w;
    w = s == 2 ? 8 : 14;
    nd = 0;
    lat = -1;
    b = '0;
    o = 1'b0;
    bl = '0;
    @(negedge clk);
    drive(s, 1'b1, v);
    @(posedge clk);
    for (int k = 1; k <= w + 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(s, 1'b0, ~v);
      if (done_of(s)) begin
        nd++;
        if (lat < 0) begin
          lat = k;
          b = bcd_of(s);
          o = ovf_of(s);
          bl = blank_of(s);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy0, done0, ovf0} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl got %b want 000", {busy0, done0, ovf0}); end
    n_cmp++; if (bcd0 !== 16'h0000) begin n_bad++; $display("FAIL reset_bcd got %h want 0000", bcd0); end
    n_cmp++; if (blank0 !== 4'b1110) begin n_bad++; $display("FAIL reset_blank got %b want 1110", blank0); end
    n_cmp++; if (blank2 !== 3'b110) begin n_bad++; $display("FAIL reset_blank_small got %b want 110", blank2); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [15:0] b; logic o; logic [3:0] bl; int nd, lat;
    convert(0, 14'd0, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h0000, 1'b0, 4'b1110}) begin n_bad++; $display("FAIL zero got %h/%b/%b want 0000/0/1110", b, o, bl); end
    n_cmp++; if (lat !== 15) begin n_bad++; $display("FAIL zero_latency got %0d want 15", lat); end
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL zero_done_count got %0d want 1", nd); end
    convert(0, 14'd9999, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h9999, 1'b0, 4'b0000}) begin n_bad++; $display("FAIL max9999 got %h/%b/%b want 9999/0/0000", b, o, bl); end
    convert(0, 14'd10, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h0010, 1'b0, 4'b1100}) begin n_bad++; $display("FAIL ten got %h/%b/%b want 0010/0/1100", b, o, bl); end
    convert(0, 14'd12345, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h9999, 1'b1, 4'b0000}) begin n_bad++; $display("FAIL sat_ovf got %h/%b/%b want 9999/1/0000", b, o, bl); end
    convert(1, 14'd12345, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h2345, 1'b1, 4'b0000}) begin n_bad++; $display("FAIL mod_ovf got %h/%b/%b want 2345/1/0000", b, o, bl); end
    convert(2, 14'd255, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h0255, 1'b0, 4'b0000}) begin n_bad++; $display("FAIL small255 got %h/%b/%b want 0255/0/0000", b, o, bl); end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL small_latency got %0d want 9", lat); end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] b; logic o; logic [3:0] bl; int nd, lat;
    nd = 0;
    @(negedge clk);
    drive(0, 1'b1, 14'd42);
    @(posedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1 || k == 6 || k == 16) drive(0, 1'b0, 14'd42);
      if (k == 5 || k == 15) drive(0, 1'b1, 14'd7);
      if (k == 5) begin
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL busy_mid got %b want 1", busy0); end
      end
      if (done0) begin
        nd++;
        b = bcd0;
      end
    end
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", nd); end
    n_cmp++; if (b !== 16'h0042) begin n_bad++; $display("FAIL ignore_bcd got %h want 0042", b); end
    convert(0, 14'd7, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h0007, 1'b0, 4'b1110}) begin n_bad++; $display("FAIL after_ignore got %h/%b/%b want 0007/0/1110", b, o, bl); end
  endtask

  task automatic test_abort;
    logic [15:0] b; logic o; logic [3:0] bl; int nd, lat;
    nd = 0;
    @(negedge clk);
    drive(0, 1'b1, 14'd8000);
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1'b0, 14'd8000);
      if (k == 6) begin
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy0, done0, ovf0} !== 3'b000) begin n_bad++; $display("FAIL abort_ctrl got %b want 000", {busy0, done0, ovf0}); end
        n_cmp++; if (bcd0 !== 16'h0000) begin n_bad++; $display("FAIL abort_bcd got %h want 0000", bcd0); end
      end
      if (k == 8) rst_n = 1'b1;
      if (done0) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL abort_done_count got %0d want 0", nd); end
    convert(0, 14'd8000, b, o, bl, nd, lat);
    n_cmp++; if ({b, o, bl} !== {16'h8000, 1'b0, 4'b0000}) begin n_bad++; $display("FAIL after_abort got %h/%b/%b want 8000/0/0000", b, o, bl); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] b1, b2; int nd, l1, l2;
    nd = 0; l1 = -1; l2 = -1; b1 = '0; b2 = '0;
    @(negedge clk);
    drive(0, 1'b1, 14'd1234);
    @(posedge clk);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1'b1, 14'd5678);
      if (k == 17) drive(0, 1'b0, 14'd0);
      if (done0) begin
        nd++;
        if (nd == 1) begin l1 = k; b1 = bcd0; end
        if (nd == 2) begin l2 = k; b2 = bcd0; end
      end
    end
    n_cmp++; if (nd !== 2) begin n_bad++; $display("FAIL b2b_done_count got %0d want 2", nd); end
    n_cmp++; if ({l1, l2} !== {32'd15, 32'd31}) begin n_bad++; $display("FAIL b2b_timing got %0d,%0d want 15,31", l1, l2); end
    n_cmp++; if ({b1, b2} !== {16'h1234, 16'h5678}) begin n_bad++; $display("FAIL b2b_values got %h,%h want 1234,5678", b1, b2); end
  endtask

  task automatic test_random;
    logic [15:0] b, eb; logic o, eo; logic [3:0] bl, ebl; int nd, lat, s, w;
    logic [13:0] v;
    for (int n = 0; n < 70; n++) begin
      s = n < 50 ? n % 2 : 2;
      v = s == 2 ? 14'($urandom_range(0, 255)) : 14'($urandom_range(0, 16383));
      w = s == 2 ? 8 : 14;
      model(v, s == 2 ? 3 : 4, s != 1, eb, eo, ebl);
      convert(s, v, b, o, bl, nd, lat);
      n_cmp++; if ({b, o, bl} !== {eb, eo, ebl}) begin n_bad++; $display("FAIL rand_result dut%0d bin=%0d got %h/%b/%b want %h/%b/%b", s, v, b, o, bl, eb, eo, ebl); end
      n_cmp++; if (nd !== 1 || lat !== w + 1) begin n_bad++; $display("FAIL rand_handshake dut%0d bin=%0d got done=%0d lat=%0d want 1/%0d", s, v, nd, lat, w + 1); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
